// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// instruction-memory geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    DONE,
    ERROR
  } state_e;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 16;

  // States in which the loader is consuming the framed byte stream.
  function automatic logic isReceiving(input state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Cycle-enabled inactivity counter; expire_o pulses on the enabled cycle
// that completes TIMEOUT_CYCLES counts without a clear.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (en_i) begin
      if (clr_i) begin
        count_d = '0;
      end else if (count_q == LAST) begin
        expire_o = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/insmem_loader.sv
// Fills instruction memory from a framed byte stream (length, payload,
// XOR checksum) while holding the CPU in reset.
module insmem_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk_pi,
  input  logic                   reset_pi,
  input  logic                   clk_en_pi,
  input  logic                   start_pi,
  input  logic                   byte_valid_pi,
  input  logic [7:0]             byte_data_pi,
  output logic                   byte_ready_po,
  output logic                   imem_we_po,
  output logic [IMEM_ADDR_W-1:0] imem_addr_po,
  output logic [IMEM_DATA_W-1:0] imem_wdata_po,
  output logic                   cpu_hold_po,
  output logic                   done_po,
  output logic                   error_po
);

  state_e                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [IMEM_ADDR_W-1:0] wordIdx_q, wordIdx_d;
  logic [7:0]             hiByte_q, hiByte_d;
  logic [7:0]             csum_q, csum_d;
  logic                   we_q, we_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [IMEM_DATA_W-1:0] wdata_q, wdata_d;

  logic        receiving;
  logic        accept;
  logic        timeoutExpire;
  logic [15:0] lenFull;

  assign receiving     = isReceiving(state_q);
  assign byte_ready_po = clk_en_pi & receiving;
  assign accept        = byte_ready_po & byte_valid_pi;
  assign lenFull       = {len_q[15:8], byte_data_pi};

  // Counter is held clear outside the receive states, so entering LEN_HI starts it from zero.
  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_pi),
    .reset_i (reset_pi),
    .en_i    (clk_en_pi),
    .clr_i   (~receiving | accept),
    .expire_o(timeoutExpire)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wordIdx_d = wordIdx_q;
    hiByte_d  = hiByte_q;
    csum_d    = csum_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (clk_en_pi) begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start_pi) begin
            state_d   = LEN_HI;
            wordIdx_d = '0;
            csum_d    = '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_d   = {byte_data_pi, len_q[7:0]};
            state_d = LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_d = lenFull;
            if ({1'b0, lenFull} > 17'(MAX_WORDS)) state_d = ERROR;
            else if (lenFull == 16'd0)            state_d = CSUM;
            else                                  state_d = DATA_HI;
          end
        end
        DATA_HI: begin
          if (accept) begin
            hiByte_d = byte_data_pi;
            csum_d   = csum_q ^ byte_data_pi;
            state_d  = DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            we_d      = 1'b1;
            addr_d    = wordIdx_q;
            wdata_d   = {hiByte_q, byte_data_pi};
            csum_d    = csum_q ^ byte_data_pi;
            wordIdx_d = wordIdx_q + 16'd1;
            state_d   = (wordIdx_q + 16'd1 == len_q) ? CSUM : DATA_HI;
          end
        end
        CSUM: begin
          if (accept) state_d = (byte_data_pi == csum_q) ? DONE : ERROR;
        end
        default: state_d = IDLE;
      endcase
      if (timeoutExpire) state_d = ERROR;
    end
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q   <= IDLE;
      len_q     <= '0;
      wordIdx_q <= '0;
      hiByte_q  <= '0;
      csum_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wordIdx_q <= wordIdx_d;
      hiByte_q  <= hiByte_d;
      csum_q    <= csum_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign imem_we_po    = we_q;
  assign imem_addr_po  = addr_q;
  assign imem_wdata_po = wdata_q;
  assign cpu_hold_po   = (state_q != IDLE) && (state_q != DONE);
  assign done_po       = (state_q == DONE);
  assign error_po      = (state_q == ERROR);

endmodule

// File: tb/tb_insmem_loader.sv
// Directed bench for insmem_loader: a table of whole frames followed by
// hand-written sequences for reset, timeout and start-handling corners.
module tb_insmem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        clkEn;
  logic        start;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteReady;
  logic        imemWe;
  logic [15:0] imemAddr;
  logic [15:0] imemWdata;
  logic        cpuHold;
  logic        done;
  logic        error;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [15:0] wrAddr[$];
  logic [15:0] wrData[$];

  typedef struct {
    int          nBytes;
    logic [63:0] bytes;
    logic        expDone;
    logic        expErr;
    int          expWrites;
    logic [15:0] expData0;
    logic [15:0] expData1;
  } vec_t;

  vec_t vecs[6];

  insmem_loader #(
    .MAX_WORDS     (256),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_pi        (clk),
    .reset_pi      (reset),
    .clk_en_pi     (clkEn),
    .start_pi      (start),
    .byte_valid_pi (byteValid),
    .byte_data_pi  (byteData),
    .byte_ready_po (byteReady),
    .imem_we_po    (imemWe),
    .imem_addr_po  (imemAddr),
    .imem_wdata_po (imemWdata),
    .cpu_hold_po   (cpuHold),
    .done_po       (done),
    .error_po      (error)
  );

  always #5 clk = ~clk;

  // Every strobe cycle seen on the falling edge is one logged write.
  always @(negedge clk) begin
    if (imemWe) begin
      wrAddr.push_back(imemAddr);
      wrData.push_back(imemWdata);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waited;
    @(negedge clk);
    byteValid = 1'b1;
    byteData  = b;
    waited    = 0;
    while (!byteReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL readyWait: got ready=0 expected ready=1 within 50 cycles");
    end
    @(posedge clk);
    #1 byteValid = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    wrAddr.delete();
    wrData.delete();
    pulseStart();
    @(negedge clk);
    checkOutput($sformatf("v%0d holdDuringLoad", idx), 32'(cpuHold), 32'd1);
    for (int i = 0; i < vecs[idx].nBytes; i++)
      sendByte(vecs[idx].bytes[63-8*i -: 8]);
    @(negedge clk);
    checkOutput($sformatf("v%0d done", idx), 32'(done), 32'(vecs[idx].expDone));
    checkOutput($sformatf("v%0d error", idx), 32'(error), 32'(vecs[idx].expErr));
    checkOutput($sformatf("v%0d hold", idx), 32'(cpuHold), 32'(!vecs[idx].expDone));
    checkOutput($sformatf("v%0d readyAfter", idx), 32'(byteReady), 32'd0);
    checkOutput($sformatf("v%0d writeCount", idx), 32'(wrData.size()), 32'(vecs[idx].expWrites));
    if (vecs[idx].expWrites > 0 && wrData.size() > 0) begin
      checkOutput($sformatf("v%0d addr0", idx), 32'(wrAddr[0]), 32'h0);
      checkOutput($sformatf("v%0d data0", idx), 32'(wrData[0]), 32'(vecs[idx].expData0));
    end
    if (vecs[idx].expWrites > 1 && wrData.size() > 1) begin
      checkOutput($sformatf("v%0d addr1", idx), 32'(wrAddr[1]), 32'h1);
      checkOutput($sformatf("v%0d data1", idx), 32'(wrData[1]), 32'(vecs[idx].expData1));
    end
  endtask

  initial begin
    vecs[0] = '{7, 64'h0002_1234_ABCD_4000, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD};
    vecs[1] = '{3, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 0, 16'h0000, 16'h0000};
    vecs[2] = '{5, 64'h0001_BEEF_0000_0000, 1'b0, 1'b1, 1, 16'hBEEF, 16'h0000};
    vecs[3] = '{5, 64'h0001_55AA_FF00_0000, 1'b1, 1'b0, 1, 16'h55AA, 16'h0000};
    vecs[4] = '{2, 64'h0101_0000_0000_0000, 1'b0, 1'b1, 0, 16'h0000, 16'h0000};
    vecs[5] = '{5, 64'h0001_0000_0000_0000, 1'b1, 1'b0, 1, 16'h0000, 16'h0000};

    reset     = 1'b1;
    clkEn     = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteData  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst ready", 32'(byteReady), 32'd0);
    checkOutput("rst we", 32'(imemWe), 32'd0);
    checkOutput("rst addr", 32'(imemAddr), 32'd0);
    checkOutput("rst wdata", 32'(imemWdata), 32'd0);
    checkOutput("rst hold", 32'(cpuHold), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst error", 32'(error), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) applyStimulus(v);

    $display("[TB] start pulse inside a load");
    wrData.delete();
    wrAddr.delete();
    pulseStart();
    sendByte(8'h00);
    sendByte(8'h01);
    pulseStart();
    sendByte(8'hAB);
    sendByte(8'hCD);
    sendByte(8'h66);
    @(negedge clk);
    checkOutput("ignStart done", 32'(done), 32'd1);
    checkOutput("ignStart writes", 32'(wrData.size()), 32'd1);
    if (wrData.size() > 0) checkOutput("ignStart data", 32'(wrData[0]), 32'hABCD);

    $display("[TB] length equal to MAX_WORDS, then reset mid-load");
    pulseStart();
    sendByte(8'h01);
    sendByte(8'h00);
    @(negedge clk);
    checkOutput("maxLen error", 32'(error), 32'd0);
    checkOutput("maxLen ready", 32'(byteReady), 32'd1);
    sendByte(8'h12);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midRst hold", 32'(cpuHold), 32'd0);
    checkOutput("midRst ready", 32'(byteReady), 32'd0);
    checkOutput("midRst error", 32'(error), 32'd0);
    checkOutput("midRst done", 32'(done), 32'd0);
    checkOutput("midRst wdata", 32'(imemWdata), 32'd0);

    $display("[TB] timeout with enable held high");
    pulseStart();
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'h12);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("to15 error", 32'(error), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("to16 error", 32'(error), 32'd1);
    checkOutput("to16 hold", 32'(cpuHold), 32'd1);

    $display("[TB] timeout with enable toggling");
    pulseStart();
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'h12);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 32) checkOutput("toEn31 error", 32'(error), 32'd0);
      clkEn = (k % 2 == 0);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("toEn32 error", 32'(error), 32'd1);
    clkEn = 1'b1;

    $display("[TB] start together with reset");
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rstStart hold", 32'(cpuHold), 32'd0);
    checkOutput("rstStart error", 32'(error), 32'd0);
    checkOutput("rstStart ready", 32'(byteReady), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
